// File: rtl/fanout_ctrl_pkg.sv
// rtl/fanout_ctrl_pkg.sv - shared types and defaults for the fanout stimulus controller
package fanout_ctrl_pkg;

    localparam int NUM_BRANCH_DEF = 4;
    localparam int PW_W_DEF       = 8;
    localparam int CNT_W_DEF      = 16;
    localparam int ERR_W_DEF      = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HIGH   = 2'd1,
        LOW    = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/fanout_err_counter.sv
// rtl/fanout_err_counter.sv - saturating per-branch mismatch counter
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset
//   clr   in   synchronous clear (start of a new run)
//   inc   in   count one mismatch this cycle
//   count out  current count, sticks at all-ones
module fanout_err_counter #(
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [ERR_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != {ERR_W{1'b1}})) begin
            count <= count + ERR_W'(1);
        end
    end

endmodule

// File: rtl/fanout_stim_ctrl.sv
// rtl/fanout_stim_ctrl.sv - pulse-train stimulus and per-branch checker for the NOR2 fanout structure
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           begin a run (accepted only in IDLE)
//   pulse_width     high-phase length, 0 behaves as 1
//   pulse_gap       low-phase length, 0 behaves as 1
//   settle_cycles   sample offset within each phase, clamped to the phase length
//   num_pulses      pulses per run
//   branch_in       fanout branch outputs, bit k = branch k+1
//   stim_out        trunk input drive
//   busy, done      run in progress / one-cycle end-of-run pulse
//   err_cnt         per-branch saturating mismatch counts
//   err_any         any counter nonzero (one cycle behind the counters)
module fanout_stim_ctrl
    import fanout_ctrl_pkg::*;
#(
    parameter int NUM_BRANCH = NUM_BRANCH_DEF,
    parameter int PW_W       = PW_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int ERR_W      = ERR_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [PW_W-1:0]             pulse_width,
    input  logic [PW_W-1:0]             pulse_gap,
    input  logic [PW_W-1:0]             settle_cycles,
    input  logic [CNT_W-1:0]            num_pulses,
    input  logic [NUM_BRANCH-1:0]       branch_in,
    output logic                        stim_out,
    output logic                        busy,
    output logic                        done,
    output logic [NUM_BRANCH*ERR_W-1:0] err_cnt,
    output logic                        err_any
);

    state_t           state;
    logic [PW_W-1:0]  high_len;
    logic [PW_W-1:0]  low_len;
    logic [PW_W-1:0]  settle_r;
    logic [CNT_W-1:0] num_r;
    logic [PW_W-1:0]  phase;
    logic [CNT_W-1:0] pulse_cnt;

    logic [PW_W-1:0]  cur_len;
    logic [PW_W-1:0]  last_idx;
    logic [PW_W-1:0]  sample_idx;
    logic             sample_en;
    logic             expected;
    logic             accept;
    logic [CNT_W-1:0] pulse_next;

    assign accept     = (state == IDLE) && start;
    assign cur_len    = (state == HIGH) ? high_len : low_len;
    // lengths are never zero once latched, so last_idx cannot underflow
    assign last_idx   = cur_len - PW_W'(1);
    assign sample_idx = (settle_r > last_idx) ? last_idx : settle_r;
    assign sample_en  = ((state == HIGH) || (state == LOW)) && (phase == sample_idx);
    assign expected   = (state == HIGH);
    assign pulse_next = pulse_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            high_len  <= PW_W'(1);
            low_len   <= PW_W'(1);
            settle_r  <= '0;
            num_r     <= '0;
            phase     <= '0;
            pulse_cnt <= '0;
            stim_out  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        high_len  <= (pulse_width == '0) ? PW_W'(1) : pulse_width;
                        low_len   <= (pulse_gap == '0) ? PW_W'(1) : pulse_gap;
                        settle_r  <= settle_cycles;
                        num_r     <= num_pulses;
                        phase     <= '0;
                        pulse_cnt <= '0;
                        if (num_pulses == '0) begin
                            // empty run: straight to FINISH, where busy is low
                            state    <= FINISH;
                            done     <= 1'b1;
                            stim_out <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            state    <= HIGH;
                            stim_out <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (phase == last_idx) begin
                        state    <= LOW;
                        phase    <= '0;
                        stim_out <= 1'b0;
                    end else begin
                        phase <= phase + PW_W'(1);
                    end
                end
                LOW: begin
                    if (phase == last_idx) begin
                        phase     <= '0;
                        pulse_cnt <= pulse_next;
                        if (pulse_next == num_r) begin
                            state <= FINISH;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= HIGH;
                            stim_out <= 1'b1;
                        end
                    end else begin
                        phase <= phase + PW_W'(1);
                    end
                end
                FINISH: begin
                    state    <= IDLE;
                    stim_out <= 1'b0;
                    busy     <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    stim_out <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_BRANCH; k++) begin : g_err
            fanout_err_counter #(
                .ERR_W(ERR_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .clr   (accept),
                .inc   (sample_en && (branch_in[k] != expected)),
                .count (err_cnt[k*ERR_W +: ERR_W])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            err_any <= 1'b0;
        end else begin
            err_any <= |err_cnt;
        end
    end

endmodule

// File: tb/tb_fanout_stim_ctrl.sv
// tb/tb_fanout_stim_ctrl.sv - randomized self-checking bench for fanout_stim_ctrl
module tb_fanout_stim_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  pulse_width = '0;
    logic [7:0]  pulse_gap = '0;
    logic [7:0]  settle_cycles = '0;
    logic [15:0] num_pulses = '0;
    logic [3:0]  branch_in;
    logic        stim_out, busy, done, err_any;
    logic [63:0] err_cnt;
    logic        s_stim, s_busy, s_done, s_err_any;
    logic [11:0] s_err_cnt;

    logic [1:0]  mode [4];
    int          dly  [4];
    logic [7:0]  hist = '0;

    int n_cmp = 0;
    int n_bad = 0;
    bit wave_q[$];

    always #5 clk = ~clk;

    fanout_stim_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .pulse_width(pulse_width), .pulse_gap(pulse_gap),
        .settle_cycles(settle_cycles), .num_pulses(num_pulses),
        .branch_in(branch_in), .stim_out(stim_out), .busy(busy),
        .done(done), .err_cnt(err_cnt), .err_any(err_any)
    );

    fanout_stim_ctrl #(.ERR_W(3)) dut_sat (
        .clk(clk), .rst(rst), .start(start),
        .pulse_width(pulse_width), .pulse_gap(pulse_gap),
        .settle_cycles(settle_cycles), .num_pulses(num_pulses),
        .branch_in(branch_in), .stim_out(s_stim), .busy(s_busy),
        .done(s_done), .err_cnt(s_err_cnt), .err_any(s_err_any)
    );

    // fault model of the fanout structure: 0 ideal, 1 stuck-0, 2 stuck-1, 3 delayed
    always @(posedge clk) hist <= {hist[6:0], stim_out};

    always_comb begin
        branch_in = '0;
        for (int k = 0; k < 4; k++) begin
            case (mode[k])
                2'd0:    branch_in[k] = stim_out;
                2'd1:    branch_in[k] = 1'b0;
                2'd2:    branch_in[k] = 1'b1;
                default: branch_in[k] = hist[dly[k]-1];
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // value branch k shows in run cycle t (cycle 1 = first cycle after start)
    function automatic bit bval(int k, int t);
        case (mode[k])
            2'd0:    return wave_q[t-1];
            2'd1:    return 1'b0;
            2'd2:    return 1'b1;
            default: return (t - dly[k] >= 1) ? wave_q[t-dly[k]-1] : 1'b0;
        endcase
    endfunction

    task automatic scramble();
        pulse_width   = 8'($urandom);
        pulse_gap     = 8'($urandom);
        settle_cycles = 8'($urandom);
        num_pulses    = 16'($urandom);
    endtask

    task automatic run(input int w, input int g, input int s, input int n, input bit hold);
        int wl = (w == 0) ? 1 : w;
        int gl = (g == 0) ? 1 : g;
        int len_tot = n * (wl + gl);
        int e[4];
        int t;
        bit any;
        wave_q.delete();
        for (int p = 0; p < n; p++) begin
            repeat (wl) wave_q.push_back(1'b1);
            repeat (gl) wave_q.push_back(1'b0);
        end
        for (int k = 0; k < 4; k++) e[k] = 0;
        t = 1;
        for (int p = 0; p < n; p++) begin
            for (int ph = 0; ph < 2; ph++) begin
                int len = (ph == 0) ? wl : gl;
                int idx = (s < len - 1) ? s : len - 1;
                for (int k = 0; k < 4; k++)
                    if (bval(k, t + idx) != (ph == 0)) e[k]++;
                t += len;
            end
        end
        any = 1'b0;
        for (int k = 0; k < 4; k++) if (e[k] != 0) any = 1'b1;

        @(negedge clk);
        pulse_width   = 8'(w);
        pulse_gap     = 8'(g);
        settle_cycles = 8'(s);
        num_pulses    = 16'(n);
        start         = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        scramble();
        for (int c = 1; c <= len_tot + 2; c++) begin
            @(negedge clk);
            chk("stim", 32'(stim_out), (c <= len_tot) ? 32'(wave_q[c-1]) : 32'd0);
            chk("busy", 32'(busy), 32'(c <= len_tot));
            chk("done", 32'(done), 32'(c == len_tot + 1));
            scramble();
            if (c == len_tot + 2) start = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("err%0d", k), 32'(err_cnt[k*16 +: 16]), 32'(e[k]));
            chk($sformatf("sat%0d", k), 32'(s_err_cnt[k*3 +: 3]), (e[k] > 7) ? 32'd7 : 32'(e[k]));
        end
        chk("err_any", 32'(err_any), 32'(any));
        chk("sat_any", 32'(s_err_any), 32'(any));
        repeat (6) @(negedge clk);
    endtask

    task automatic set_modes(input int m0, input int m1, input int m2, input int m3);
        mode[0] = 2'(m0); mode[1] = 2'(m1); mode[2] = 2'(m2); mode[3] = 2'(m3);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) dly[k] = 1;
        set_modes(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_stim", 32'(stim_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", err_cnt[31:0], 32'd0);
        chk("rst_any", 32'(err_any), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(4, 4, 2, 3, 1'b0);                       // ideal
        set_modes(0, 0, 1, 0); run(3, 3, 1, 5, 1'b0); // branch 3 stuck-0
        set_modes(0, 0, 0, 0); run(5, 2, 1, 0, 1'b0); // empty run
        run(0, 0, 0, 2, 1'b0);                       // 1-cycle phases
        set_modes(2, 0, 0, 0); run(2, 2, 1, 10, 1'b0); // saturation
        set_modes(0, 0, 0, 0); run(3, 2, 1, 3, 1'b1); // start held high
        set_modes(0, 0, 0, 3); dly[3] = 3;
        run(6, 6, 1, 2, 1'b0);                       // slow branch, early sample
        run(6, 6, 4, 2, 1'b0);                       // slow branch, late sample

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) begin
                mode[k] = 2'($urandom_range(0, 3));
                dly[k]  = $urandom_range(1, 4);
            end
            run($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 7),
                $urandom_range(0, 5), 1'($urandom_range(0, 1)));
        end

        // reset in the middle of a HIGH phase
        set_modes(1, 0, 0, 0);
        @(negedge clk);
        pulse_width = 8'd5; pulse_gap = 8'd3; settle_cycles = 8'd0; num_pulses = 16'd2;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_err", 32'(err_cnt[15:0]), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_stim", 32'(stim_out), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err", 32'(err_cnt[15:0]), 32'd0);
        chk("mid_rst_any", 32'(err_any), 32'd0);
        repeat (3) @(negedge clk);
        chk("post_rst_stim", 32'(stim_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
